// File: rtl/dir_command_gen.sv
// rtl/dir_command_gen.sv - debounced push-button to one-cycle direction/place command generator
// Optional auto-repeat of the held direction is compiled in with `define AUTO_REPEAT_EN.
module dir_command_gen #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_right,
   input  logic       btn_left,
   input  logic       btn_place,
   output logic [2:0] dir,
   output logic       place
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 20'hFFFFF) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range");
   end
   if (REPEAT_DELAY < 1 || REPEAT_DELAY > 24'hFFFFFF) begin : g_bad_delay
      $error("REPEAT_DELAY out of range");
   end
   if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 24'hFFFFFF) begin : g_bad_period
      $error("REPEAT_PERIOD out of range");
   end

   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   // Bit order: 0 up, 1 down, 2 right, 3 left, 4 place; direction code is index+1.
   logic [4:0]  raw;
   logic [4:0]  sync1;
   logic [4:0]  sync2;
   logic [4:0]  db;
   logic [4:0]  db_prev;
   logic [4:0]  rise_q;
   logic [19:0] cnt [5];
   logic [2:0]  win_code;

   assign raw = {btn_place, btn_left, btn_right, btn_down, btn_up};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         db      <= '0;
         db_prev <= '0;
         rise_q  <= '0;
         place   <= 1'b0;
         for (int i = 0; i < 5; i++) cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         db_prev <= db;
         rise_q  <= db & ~db_prev;
         place   <= rise_q[4];
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] != db[i]) begin
               if (cnt[i] == DB_LAST) begin
                  db[i]  <= sync2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 20'd1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Losing simultaneous edges are simply discarded.
   always_comb begin
      win_code = 3'd0;
      if (rise_q[0])      win_code = 3'd1;
      else if (rise_q[1]) win_code = 3'd2;
      else if (rise_q[2]) win_code = 3'd3;
      else if (rise_q[3]) win_code = 3'd4;
   end

`ifdef AUTO_REPEAT_EN
   localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
   localparam logic [23:0] RP_LAST = 24'(REPEAT_PERIOD - 1);

   logic        rep_on;
   logic        rep_first;
   logic [2:0]  rep_code;
   logic [23:0] rep_cnt;
   logic        rep_held;
   logic [23:0] rep_last;

   always_comb begin
      rep_held = 1'b0;
      case (rep_code)
         3'd1:    rep_held = db[0];
         3'd2:    rep_held = db[1];
         3'd3:    rep_held = db[2];
         3'd4:    rep_held = db[3];
         default: rep_held = 1'b0;
      endcase
      rep_last = rep_first ? RD_LAST : RP_LAST;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dir       <= 3'd0;
         rep_on    <= 1'b0;
         rep_first <= 1'b0;
         rep_code  <= 3'd0;
         rep_cnt   <= '0;
      end else if (win_code != 3'd0) begin
         dir       <= win_code;
         rep_on    <= 1'b1;
         rep_first <= 1'b1;
         rep_code  <= win_code;
         rep_cnt   <= '0;
      end else if (rep_on && !rep_held) begin
         dir    <= 3'd0;
         rep_on <= 1'b0;
      end else if (rep_on && rep_cnt == rep_last) begin
         dir       <= rep_code;
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else begin
         dir <= 3'd0;
         if (rep_on) rep_cnt <= rep_cnt + 24'd1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) dir <= 3'd0;
      else       dir <= win_code;
   end
`endif

endmodule

// File: tb/tb_dir_command_gen.sv
// tb/tb_dir_command_gen.sv - randomized self-checking bench for dir_command_gen
// Honours AUTO_REPEAT_EN the same way the design does.
module tb_dir_command_gen;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;
   localparam int NMAX = 8192;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up, btn_down, btn_right, btn_left, btn_place;
   logic [2:0] dir;
   logic       place;

   always #5 clk = ~clk;

   dir_command_gen #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_right(btn_right),
      .btn_left(btn_left),
      .btn_place(btn_place),
      .dir(dir),
      .place(place)
   );

   int total = 0;
   int bad   = 0;
   int n     = 0;

   // Model: debounce in raw-sample time; every accepted change shows up 4 edges later.
   logic [2:0] exp_dir_at [NMAX];
   logic       exp_pl_at  [NMAX];
   logic [4:0] deb_hist   [NMAX];
   logic [4:0] m_deb;
   int         m_run [5];
   logic       rep_on;
   int         rep_btn;
   int         next_due;
   logic [2:0] obs_dir;
   int         left_pulses;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, n);
      end
   endtask

   task automatic step(input logic [4:0] raw, input logic rst);
      logic [2:0] ed;
      logic       ep;
      logic [4:0] rise;
      int         win;
      {btn_place, btn_left, btn_right, btn_down, btn_up} = raw;
      reset = rst;
      @(posedge clk);
      ed = 3'd0;
      ep = 1'b0;
      rise = '0;
      win = 0;
      if (rst) begin
         m_deb = '0;
         for (int b = 0; b < 5; b++) m_run[b] = 0;
         for (int k = 0; k <= 4; k++) begin
            exp_dir_at[n + k] = 3'd0;
            exp_pl_at[n + k]  = 1'b0;
         end
         rep_on = 1'b0;
      end else begin
         for (int b = 0; b < 5; b++) begin
            if (raw[b] != m_deb[b]) begin
               m_run[b]++;
               if (m_run[b] == D) begin
                  m_deb[b] = raw[b];
                  m_run[b] = 0;
                  rise[b]  = raw[b];
               end
            end else begin
               m_run[b] = 0;
            end
         end
         for (int b = 3; b >= 0; b--) if (rise[b]) win = b + 1;
         if (win != 0) exp_dir_at[n + 4] = 3'(win);
         if (rise[4])  exp_pl_at[n + 4]  = 1'b1;
         ep = exp_pl_at[n];
         if (exp_dir_at[n] != 3'd0) begin
            ed       = exp_dir_at[n];
            rep_on   = 1'b1;
            rep_btn  = int'(ed) - 1;
            next_due = n + RD;
         end
`ifdef AUTO_REPEAT_EN
         else if (rep_on) begin
            if (!deb_hist[n - 3][rep_btn]) begin
               rep_on = 1'b0;
            end else if (n == next_due) begin
               ed       = 3'(rep_btn + 1);
               next_due = n + RP;
            end
         end
`endif
      end
      deb_hist[n] = m_deb;
      @(negedge clk);
      obs_dir = dir;
      check("dir", {29'd0, dir}, {29'd0, ed});
      check("place", {31'd0, place}, {31'd0, ep});
      check("dir_legal", {31'd0, (dir <= 3'd4)}, 32'd1);
      n++;
   endtask

   task automatic do_reset();
      step(5'b00000, 1'b1);
      step(5'b00000, 1'b1);
   endtask

   logic [4:0] cur;
   int         pflip;

   initial begin
      for (int i = 0; i < NMAX; i++) begin
         exp_dir_at[i] = 3'd0;
         exp_pl_at[i]  = 1'b0;
         deb_hist[i]   = 5'd0;
      end
      m_deb  = '0;
      rep_on = 1'b0;
      rep_btn = 0;
      next_due = 0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;

      // Right held 20 cycles: single pulse at edge 7
      do_reset();
      check("reset_dir", {29'd0, dir}, 32'd0);
      check("reset_place", {31'd0, place}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         step((i < 20) ? 5'b00100 : 5'b00000, 1'b0);
         if (i == 7) check("right_edge7", {29'd0, obs_dir}, 32'd3);
      end

      // Short up glitch: nothing
      do_reset();
      for (int i = 0; i < 15; i++) step((i < 3) ? 5'b00001 : 5'b00000, 1'b0);

      // Down and left together: down wins
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(5'b01010, 1'b0);
         if (i == 7) check("down_wins", {29'd0, obs_dir}, 32'd2);
      end
      for (int i = 0; i < 10; i++) step(5'b00000, 1'b0);

      // Place and up together
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(5'b10001, 1'b0);
         if (i == 7) check("place_up_dir", {29'd0, obs_dir}, 32'd1);
         if (i == 7) check("place_up_place", {31'd0, place}, 32'd1);
      end
      for (int i = 0; i < 10; i++) step(5'b00000, 1'b0);

      // Left held, reset pulsed at edge 5
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(5'b01000, i == 5);
         if (i == 7)  check("rst_cancel", {29'd0, obs_dir}, 32'd0);
         if (i == 13) check("rst_repress", {29'd0, obs_dir}, 32'd4);
      end
      for (int i = 0; i < 10; i++) step(5'b00000, 1'b0);

      // Left held edges 0-39
      do_reset();
      left_pulses = 0;
      for (int i = 0; i < 60; i++) begin
         step((i < 40) ? 5'b01000 : 5'b00000, 1'b0);
         if (obs_dir == 3'd4) left_pulses++;
      end
`ifdef AUTO_REPEAT_EN
      check("left_pulse_count", left_pulses, 32'd7);
`else
      check("left_pulse_count", left_pulses, 32'd1);
`endif

      // Random bouncing buttons with occasional resets
      do_reset();
      cur = '0;
      pflip = 20;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) pflip = ($urandom_range(0, 1) == 0) ? 3 : 20;
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, pflip - 1) == 0) cur[b] = ~cur[b];
         step(cur, $urandom_range(0, 299) == 0);
      end
      for (int i = 0; i < 10; i++) step(5'b00000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dir_command_gen.md
DIR_COMMAND_GEN -- requirements
Module: dir_command_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a button level change; legal range 1 to 2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 12500000: cycles from the first pulse to the first auto-repeat pulse; legal range 1 to 2^24-1.
REQ-003 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses; legal range 1 to 2^24-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_up, btn_down, btn_right, btn_left  input  1 each  raw push buttons, active-high, asynchronous to clk.
REQ-007 btn_place  input  1  raw place button, active-high, asynchronous to clk.
REQ-008 dir  output  3  registered direction command: Idle 000, Up 001, Down 010, Right 011, Left 100.
REQ-009 place  output  1  registered one-cycle place pulse.

Function
REQ-010 Each raw button SHALL pass through a two-flop synchroniser before any other logic.
REQ-011 Each button SHALL have a debounced state, updated only after its synchronised level differs from that state on DEBOUNCE_CYCLES consecutive cycles.
REQ-012 A mismatch run broken before it reaches DEBOUNCE_CYCLES SHALL clear that button's counter and leave its debounced state unchanged.
REQ-013 A 0->1 transition of a debounced direction state SHALL drive dir to that code for exactly one cycle; dir SHALL be 000 in all other cycles.
REQ-014 Latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges, counted from edge 0, the first edge that samples the raw button high, to the edge that registers the pulse.
REQ-015 Simultaneous direction rising edges SHALL be resolved by priority Up > Down > Right > Left.
REQ-016 Direction edges that lose priority SHALL be dropped, not queued.
REQ-017 A debounced rising edge of btn_place SHALL pulse place for exactly one cycle, with the same latency as REQ-014.
REQ-018 place SHALL be independent of dir; both may assert in the same cycle.
REQ-019 Debounced falling edges SHALL produce no output.
REQ-020 place SHALL never repeat.
REQ-021 Output legality: dir SHALL never carry the codes 101, 110 or 111.

Reset
REQ-022 While reset is high, all of the following SHALL clear to 0 at the next edge: synchroniser flops, debounced states, debounce counters, repeat counter, dir (000) and place.
REQ-023 Reset asserted mid-debounce or mid-repeat SHALL cancel any pending or repeating pulse.
REQ-024 A button held through reset deassertion SHALL be treated as a new press: a pulse follows DEBOUNCE_CYCLES+3 edges after the first non-reset edge.

Configuration
REQ-025 The macro AUTO_REPEAT_EN SHALL compile auto-repeat in or out.
REQ-026 With AUTO_REPEAT_EN defined, while the last-pulsed direction stays debounced-high, dir SHALL re-pulse that code REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
REQ-027 With AUTO_REPEAT_EN defined, repeating SHALL stop at that button's debounced release.
REQ-028 With AUTO_REPEAT_EN defined, a new winning direction edge SHALL pre-empt the current repeat and restart timing from its own pulse.
REQ-029 Without AUTO_REPEAT_EN, there SHALL be exactly one pulse per press, no repeat counter logic SHALL be present, and REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
REQ-030 btn_right high from edge 0, held 20 cycles -> dir=011 at edge 7 only; dir=000 at every other edge; place=0 throughout.
REQ-031 btn_up high for 3 cycles, then low -> dir stays 000 throughout.
REQ-032 btn_down and btn_left rise on the same edge and are held -> single dir=010 at edge 7; dir=100 never appears.
REQ-033 btn_place and btn_up rise together -> place=1 and dir=001 on the same edge (7), both for one cycle only.
REQ-034 btn_left held and reset pulsed at edge 5 -> no pulse at edge 7; with reset low from edge 6, dir=100 at edge 13.
REQ-035 btn_left held for edges 0-39 -> with AUTO_REPEAT_EN, dir=100 at edges 7, 17, 22, 27, 32, 37, 42 and none after 46; without AUTO_REPEAT_EN, the edge 7 pulse only.
